// File: rtl/scalar_loop_ctrl_if.sv
// Launch/config, datapath handshake and scalar register file command bundle
// for scalar_loop_ctrl.
interface scalar_loop_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [DATA_W-1:0] n_cfg;
  logic [DATA_W-1:0] m_cfg;
  logic              dp_ready;
  logic [1:0]        sca_reg_op;
  logic [DATA_W-1:0] imm;
  logic              idx_valid;
  logic [DATA_W-1:0] iter_i;
  logic [DATA_W-1:0] iter_j;
  logic              busy;
  logic              done;

  modport master (
    output start, n_cfg, m_cfg, dp_ready,
    input  sca_reg_op, imm, idx_valid, iter_i, iter_j, busy, done
  );

  modport slave (
    input  start, n_cfg, m_cfg, dp_ready,
    output sca_reg_op, imm, idx_valid, iter_i, iter_j, busy, done
  );
endinterface

// File: rtl/scalar_loop_ctrl.sv
// Nested-loop sequencer for the scalar i/j/n register file: programs n, then
// walks j = 0..n for each of m outer iterations with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start, op READ
// SETN  | program n into the register file (op SETN, imm = n)
// READ  | request indices; register file outputs settle next cycle
// WAIT  | indices valid, hold until datapath ready
// INCJ  | advance j (register file wraps j at n)
// INCI  | advance i after a full inner pass
// DONE  | one-cycle completion pulse
module scalar_loop_ctrl #(
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  scalar_loop_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SETN = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_INCJ = 3'd4;
  localparam logic [2:0] S_INCI = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] n_lat_q, n_lat_d;
  logic [DATA_W-1:0] m_lat_q, m_lat_d;
  logic [DATA_W-1:0] iter_i_q, iter_i_d;
  logic [DATA_W-1:0] iter_j_q, iter_j_d;

  always_comb begin
    state_d  = state_q;
    n_lat_d  = n_lat_q;
    m_lat_d  = m_lat_q;
    iter_i_d = iter_i_q;
    iter_j_d = iter_j_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_lat_d  = bus.n_cfg;
          m_lat_d  = bus.m_cfg;
          iter_i_d = '0;
          iter_j_d = '0;
          state_d  = (bus.m_cfg != '0) ? S_SETN : S_DONE;
        end
      end
      S_SETN: state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: if (bus.dp_ready) state_d = S_INCJ;
      S_INCJ: begin
        // equality wrap keeps n = all-ones legal without an overflow bit
        if (iter_j_q == n_lat_q) begin
          iter_j_d = '0;
          state_d  = S_INCI;
        end else begin
          iter_j_d = iter_j_q + ONE;
          state_d  = S_READ;
        end
      end
      S_INCI: begin
        if (iter_i_q + ONE == m_lat_q) begin
          state_d = S_DONE;
        end else begin
          iter_i_d = iter_i_q + ONE;
          state_d  = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_lat_q  <= '0;
      m_lat_q  <= '0;
      iter_i_q <= '0;
      iter_j_q <= '0;
    end else begin
      state_q  <= state_d;
      n_lat_q  <= n_lat_d;
      m_lat_q  <= m_lat_d;
      iter_i_q <= iter_i_d;
      iter_j_q <= iter_j_d;
    end
  end

  // READ (11) is the only op that leaves the register file untouched
  always_comb begin
    case (state_q)
      S_SETN:  bus.sca_reg_op = 2'b10;
      S_INCJ:  bus.sca_reg_op = 2'b01;
      S_INCI:  bus.sca_reg_op = 2'b00;
      default: bus.sca_reg_op = 2'b11;
    endcase
  end

  assign bus.imm       = (state_q == S_SETN) ? n_lat_q : '0;
  assign bus.idx_valid = (state_q == S_WAIT);
  assign bus.iter_i    = iter_i_q;
  assign bus.iter_j    = iter_j_q;
  assign bus.busy      = (state_q == S_SETN) || (state_q == S_READ) ||
                         (state_q == S_WAIT) || (state_q == S_INCJ) ||
                         (state_q == S_INCI);
  assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_scalar_loop_ctrl.sv
// Directed bench for scalar_loop_ctrl: a loop-level model expands each run into
// an expected per-cycle trace that a single compare process checks.
module tb_scalar_loop_ctrl;
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] imm;
    logic        valid;
    logic [31:0] ii;
    logic [31:0] jj;
    logic        busy;
    logic        done;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  rec_t exp_q[$];

  scalar_loop_ctrl_if #(.DATA_W(32)) bus ();
  scalar_loop_ctrl #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic rec_t mk(input logic [1:0] op, input logic [31:0] imm, input logic valid,
                              input logic [31:0] ii, input logic [31:0] jj,
                              input logic busy, input logic done);
    rec_t r;
    r.op = op; r.imm = imm; r.valid = valid; r.ii = ii; r.jj = jj;
    r.busy = busy; r.done = done;
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      cyc++;
      check($sformatf("op c%0d", cyc),    64'(bus.sca_reg_op), 64'(e.op));
      check($sformatf("imm c%0d", cyc),   64'(bus.imm),        64'(e.imm));
      check($sformatf("valid c%0d", cyc), 64'(bus.idx_valid),  64'(e.valid));
      check($sformatf("iter_i c%0d", cyc), 64'(bus.iter_i),    64'(e.ii));
      check($sformatf("iter_j c%0d", cyc), 64'(bus.iter_j),    64'(e.jj));
      check($sformatf("busy c%0d", cyc),  64'(bus.busy),       64'(e.busy));
      check($sformatf("done c%0d", cyc),  64'(bus.done),       64'(e.done));
    end
  end

  // Called at a negedge. Expected trace follows the loop structure directly:
  // SETN, then per (i,j) READ, WAIT (plus stalls), INCJ; INCI after each inner pass.
  task automatic run(input string tag, input logic [31:0] n, input logic [31:0] m,
                     input int stall, input int rst_at, input int restart_at,
                     input int done_lit);
    rec_t        tr[$];
    rec_t        cut[$];
    logic [31:0] last_i;
    int          model_done = 0;
    int          obs_done   = 0;
    if (m != 0) tr.push_back(mk(2'b10, n, 1'b0, 0, 0, 1'b1, 1'b0));
    for (int unsigned i = 0; i < m; i++) begin
      for (int unsigned j = 0; j <= n; j++) begin
        tr.push_back(mk(2'b11, 0, 1'b0, i, j, 1'b1, 1'b0));
        for (int s = 0; s <= ((i == 0 && j == 0) ? stall : 0); s++)
          tr.push_back(mk(2'b11, 0, 1'b1, i, j, 1'b1, 1'b0));
        tr.push_back(mk(2'b01, 0, 1'b0, i, j, 1'b1, 1'b0));
      end
      tr.push_back(mk(2'b00, 0, 1'b0, i, 0, 1'b1, 1'b0));
    end
    last_i = (m != 0) ? m - 1 : 0;
    tr.push_back(mk(2'b11, 0, 1'b0, last_i, 0, 1'b0, 1'b1));
    tr.push_back(mk(2'b11, 0, 1'b0, last_i, 0, 1'b0, 1'b0));
    if (rst_at > 0) begin
      for (int k = 0; k < rst_at; k++) cut.push_back(tr[k]);
      cut.push_back(mk(2'b11, 0, 1'b0, 0, 0, 1'b0, 1'b0));
      tr = cut;
    end
    foreach (tr[k]) if (tr[k].done) model_done = k + 1;
    check({tag, " model done cycle"}, 64'(model_done), 64'(done_lit));

    bus.n_cfg = n; bus.m_cfg = m; bus.dp_ready = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
    foreach (tr[k]) exp_q.push_back(tr[k]);
    for (int k = 1; k <= tr.size(); k++) begin
      @(negedge clk);
      if (bus.done && obs_done == 0) obs_done = k;
      bus.dp_ready = !(k >= 3 && k < 3 + stall);
      if (restart_at > 0 && k == restart_at) begin
        bus.start = 1'b1; bus.n_cfg = 32'd7;
      end
      if (restart_at > 0 && k == restart_at + 1) bus.start = 1'b0;
      if (rst_at > 0 && k == rst_at) rst = 1'b0;
      if (rst_at > 0 && k == rst_at + 1) rst = 1'b1;
    end
    check({tag, " dut done cycle"}, 64'(obs_done), 64'(done_lit));
    #1;
    check({tag, " trace consumed"}, 64'(exp_q.size()), 64'd0);
    bus.start = 1'b0;
    bus.dp_ready = 1'b1;
  endtask

  initial begin
    bus.start = 1'b0; bus.n_cfg = '0; bus.m_cfg = '0; bus.dp_ready = 1'b1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset op",     64'(bus.sca_reg_op), 64'h3);
    check("reset imm",    64'(bus.imm),        64'h0);
    check("reset valid",  64'(bus.idx_valid),  64'h0);
    check("reset iter_i", 64'(bus.iter_i),     64'h0);
    check("reset iter_j", 64'(bus.iter_j),     64'h0);
    check("reset busy",   64'(bus.busy),       64'h0);
    check("reset done",   64'(bus.done),       64'h0);
    rst = 1'b1;
    @(negedge clk);

    run("s1 n2m1",        32'd2, 32'd1, 0, 0, 0, 12);
    run("s2 m0",          32'd5, 32'd0, 0, 0, 0, 1);
    run("s3 unstalled",   32'd1, 32'd1, 0, 0, 0, 9);
    run("s3 stall5",      32'd1, 32'd1, 5, 0, 0, 14);
    run("s4 n0m3",        32'd0, 32'd3, 0, 0, 0, 14);
    run("s5 restart",     32'd2, 32'd1, 0, 0, 5, 12);
    run("s6 reset",       32'd2, 32'd1, 0, 7, 0, 0);
    run("s6 fresh n1m2",  32'd1, 32'd2, 0, 0, 0, 16);
    run("s7 n3m2 stall2", 32'd3, 32'd2, 2, 0, 0, 1 + 2 * 13 + 1 + 2);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
